// File: rtl/hydra_pkg.sv
// Shared constants, request struct and queue indexing for the enqueue
// scheduler slice. Every hydra_* file imports this package.
package hydra_pkg;

  localparam int NUM_SRAM = 32;  // join-request sources
  localparam int NUM_PORT = 16;  // output ports
  localparam int NUM_PRIO = 8;   // priorities per port
  localparam int ADDR_W   = 16;  // packet address {sram_idx, offset}
  localparam int TS_W     = 5;   // time-stamp width; TS FIFO depth = 2**TS_W

  localparam int SRAM_W = $clog2(NUM_SRAM);
  localparam int PORT_W = $clog2(NUM_PORT);
  localparam int PRIO_W = $clog2(NUM_PRIO);
  localparam int NUM_Q  = NUM_PORT * NUM_PRIO;
  localparam int QIDX_W = $clog2(NUM_Q);

  typedef struct packed {
    logic [PORT_W-1:0] dest;
    logic [PRIO_W-1:0] prior;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [TS_W-1:0]   ts;
  } join_req_t;

  // Flat queue index: port*NUM_PRIO + prior.
  function automatic logic [QIDX_W-1:0] qidx(input logic [PORT_W-1:0] port,
                                             input logic [PRIO_W-1:0] prior);
    return QIDX_W'(port) * QIDX_W'(NUM_PRIO) + QIDX_W'(prior);
  endfunction

endpackage

// File: rtl/hydra_enqueue_scheduler_if.sv
// Bundle of all scheduler-facing signals except clk/rst_n.
//   slave  : scheduler side (join/cat/deq/rd requests in, acks/status out)
//   master : environment side (sram_interface, concat consumer, read side)
interface hydra_enqueue_scheduler_if;
  import hydra_pkg::*;

  logic [TS_W-1:0]            time_stamp;
  logic [NUM_SRAM-1:0]        join_new;
  logic [NUM_SRAM*TS_W-1:0]   join_ts;
  logic [NUM_SRAM*PORT_W-1:0] join_dest;
  logic [NUM_SRAM*PRIO_W-1:0] join_prior;
  logic [NUM_SRAM*ADDR_W-1:0] join_head;
  logic [NUM_SRAM*ADDR_W-1:0] join_tail;
  logic [NUM_SRAM-1:0]        join_ack;
  logic                       join_stall;
  logic                       cat_vld;
  logic                       cat_ready;
  logic [ADDR_W-1:0]          cat_prev;
  logic [ADDR_W-1:0]          cat_next;
  logic                       deq_vld;
  logic [PORT_W-1:0]          deq_port;
  logic [PRIO_W-1:0]          deq_prior;
  logic [ADDR_W-1:0]          deq_next_head;
  logic                       deq_last;
  logic [PORT_W-1:0]          rd_port;
  logic [PRIO_W-1:0]          rd_prior;
  logic [ADDR_W-1:0]          rd_head;
  logic [ADDR_W-1:0]          rd_tail;
  logic [NUM_Q-1:0]           q_empty;
  logic                       err;

  modport slave (
    input  time_stamp, join_new, join_ts, join_dest, join_prior, join_head, join_tail,
    input  cat_ready, deq_vld, deq_port, deq_prior, deq_next_head, deq_last,
    input  rd_port, rd_prior,
    output join_ack, join_stall, cat_vld, cat_prev, cat_next, rd_head, rd_tail,
    output q_empty, err
  );

  modport master (
    output time_stamp, join_new, join_ts, join_dest, join_prior, join_head, join_tail,
    output cat_ready, deq_vld, deq_port, deq_prior, deq_next_head, deq_last,
    output rd_port, rd_prior,
    input  join_ack, join_stall, cat_vld, cat_prev, cat_next, rd_head, rd_tail,
    input  q_empty, err
  );

endinterface

// File: rtl/hydra_ts_fifo.sv
// Circular FIFO of arrival time stamps.
// Ports: clk, rst_n (sync, active-low), push_i/push_data_i, pop_i,
//        head_o (oldest entry), empty_o, full_o.
// Push while full and pop while empty are ignored.
module hydra_ts_fifo #(
  parameter int WIDTH      = 5,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;  // extra MSB distinguishes full from empty
  logic                do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/hydra_enqueue_scheduler.sv
// Orders SRAM->port packet-join requests by arrival stamp, keeps per
// (port, priority) packet queues and issues jump-table concatenations.
// Ports: clk, rst_n (sync, active-low), bus (hydra_enqueue_scheduler_if.slave):
//   join_*  request capture / ack, join_stall = stamp FIFO full
//   cat_*   concatenation valid/ready output (old tail -> new head)
//   deq_*   head pops from the read side
//   rd_*    combinational head/tail readback, q_empty, sticky err
module hydra_enqueue_scheduler
  import hydra_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  hydra_enqueue_scheduler_if.slave bus
);

  logic [NUM_SRAM-1:0] pending_q, pending_d, mask_q, mask_d, join_ack_q, sel, clr;
  logic [ADDR_W-1:0]   head_q [NUM_Q];
  logic [ADDR_W-1:0]   tail_q [NUM_Q];
  logic [NUM_Q-1:0]    empty_q;
  logic                cat_vld_q, err_q, err_d;
  logic [ADDR_W-1:0]   cat_prev_q, cat_next_q;

  logic [SRAM_W-1:0]   sel_idx;
  logic                sel_found, stall, dispatch, cat_load, deq_ok, enq_empty;
  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [TS_W-1:0]     fifo_head;
  logic [QIDX_W-1:0]   enq_qi, deq_qi, rd_qi;
  join_req_t           req;

  hydra_ts_fifo #(.WIDTH(TS_W), .DEPTH_LOG2(TS_W)) u_ts_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (bus.time_stamp),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Eligible requests: pending, not yet served under this stamp, stamp match.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRAM; i++)
      sel[i] = pending_q[i] & mask_q[i] & ~fifo_empty &
               (bus.join_ts[i*TS_W +: TS_W] == fifo_head);
  end

  // Priority encoder, lowest index wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = NUM_SRAM-1; i >= 0; i--) begin
      if (sel[i]) begin
        sel_idx   = SRAM_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    req.dest  = bus.join_dest[sel_idx*PORT_W +: PORT_W];
    req.prior = bus.join_prior[sel_idx*PRIO_W +: PRIO_W];
    req.head  = bus.join_head[sel_idx*ADDR_W +: ADDR_W];
    req.tail  = bus.join_tail[sel_idx*ADDR_W +: ADDR_W];
    req.ts    = bus.join_ts[sel_idx*TS_W +: TS_W];
  end

  assign stall     = cat_vld_q & ~bus.cat_ready;
  assign dispatch  = sel_found & (req.ts == fifo_head) & ~stall;
  // Once no request matches the head stamp, that stamp is exhausted.
  assign fifo_pop  = ~sel_found & ~fifo_empty;
  assign fifo_push = |bus.join_new;
  assign clr       = dispatch ? (NUM_SRAM'(1) << sel_idx) : '0;

  assign deq_qi    = qidx(bus.deq_port, bus.deq_prior);
  assign deq_ok    = bus.deq_vld & ~empty_q[deq_qi];
  assign enq_qi    = qidx(req.dest, req.prior);
  // The enqueue sees the queue as it stands after a same-cycle dequeue.
  assign enq_empty = empty_q[enq_qi] | (deq_ok & bus.deq_last & (deq_qi == enq_qi));
  assign cat_load  = dispatch & ~enq_empty;

  assign pending_d = (pending_q & ~clr) | bus.join_new;
  assign mask_d    = fifo_pop ? '1 : (mask_q & ~clr);
  assign err_d     = err_q | (|(bus.join_new & pending_q)) | (fifo_push & fifo_full) |
                     (bus.deq_vld & empty_q[deq_qi]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mask_q     <= '1;
      join_ack_q <= '0;
      cat_vld_q  <= 1'b0;
      cat_prev_q <= '0;
      cat_next_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      join_ack_q <= clr;
      err_q      <= err_d;
      if (cat_load) begin
        cat_vld_q  <= 1'b1;
        cat_prev_q <= tail_q[enq_qi];
        cat_next_q <= req.head;
      end else if (bus.cat_ready) begin
        cat_vld_q  <= 1'b0;
      end
    end
  end

  // Queue table: dequeue applied first so a same-queue enqueue overrides it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      empty_q <= '1;
      for (int i = 0; i < NUM_Q; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      if (deq_ok) begin
        if (bus.deq_last) empty_q[deq_qi] <= 1'b1;
        else              head_q[deq_qi]  <= bus.deq_next_head;
      end
      if (dispatch) begin
        tail_q[enq_qi] <= req.tail;
        if (enq_empty) begin
          head_q[enq_qi]  <= req.head;
          empty_q[enq_qi] <= 1'b0;
        end
      end
    end
  end

  assign rd_qi          = qidx(bus.rd_port, bus.rd_prior);
  assign bus.rd_head    = head_q[rd_qi];
  assign bus.rd_tail    = tail_q[rd_qi];
  assign bus.q_empty    = empty_q;
  assign bus.join_ack   = join_ack_q;
  assign bus.join_stall = fifo_full;
  assign bus.cat_vld    = cat_vld_q;
  assign bus.cat_prev   = cat_prev_q;
  assign bus.cat_next   = cat_next_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_hydra_enqueue_scheduler.sv
module tb_hydra_enqueue_scheduler;
  import hydra_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  hydra_enqueue_scheduler_if bus();

  hydra_enqueue_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.time_stamp = TS_W'(bus.time_stamp + 1);
    bus.join_new   = '0;
    bus.deq_vld    = 1'b0;
  endtask

  task automatic join_req(input int s, input int d, input int p,
                          input logic [ADDR_W-1:0] h, input logic [ADDR_W-1:0] t);
    bus.join_ts[s*TS_W +: TS_W]       = bus.time_stamp;
    bus.join_dest[s*PORT_W +: PORT_W] = PORT_W'(d);
    bus.join_prior[s*PRIO_W +: PRIO_W] = PRIO_W'(p);
    bus.join_head[s*ADDR_W +: ADDR_W] = h;
    bus.join_tail[s*ADDR_W +: ADDR_W] = t;
    bus.join_new[s] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    bus.rd_port = 4'd2; bus.rd_prior = 3'd5;
    #1;
    n_checks++; if (bus.join_ack !== '0) $display("FAIL rst_ack got=%h exp=0", bus.join_ack); else n_pass++;
    n_checks++; if (bus.cat_vld !== 1'b0) $display("FAIL rst_cat_vld got=%b exp=0", bus.cat_vld); else n_pass++;
    n_checks++; if ({bus.cat_prev, bus.cat_next} !== 32'h0) $display("FAIL rst_cat_addr got=%h/%h exp=0/0", bus.cat_prev, bus.cat_next); else n_pass++;
    n_checks++; if ({bus.err, bus.join_stall} !== 2'b00) $display("FAIL rst_err_stall got=%b%b exp=00", bus.err, bus.join_stall); else n_pass++;
    n_checks++; if (bus.q_empty !== {NUM_Q{1'b1}}) $display("FAIL rst_q_empty got=%h exp=all ones", bus.q_empty); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== 32'h0) $display("FAIL rst_rd got=%h/%h exp=0/0", bus.rd_head, bus.rd_tail); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_empty_join();
    bus.time_stamp = 5'd7;
    join_req(3, 2, 5, 16'h1800, 16'h1830);
    tick();
    n_checks++; if (bus.join_ack !== '0) $display("FAIL t1_ack_early got=%h exp=0", bus.join_ack); else n_pass++;
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0008) $display("FAIL t1_ack got=%h exp=00000008", bus.join_ack); else n_pass++;
    n_checks++; if (bus.q_empty[21] !== 1'b0) $display("FAIL t1_q_empty21 got=%b exp=0", bus.q_empty[21]); else n_pass++;
    n_checks++; if (bus.rd_head !== 16'h1800) $display("FAIL t1_rd_head got=%h exp=1800", bus.rd_head); else n_pass++;
    n_checks++; if (bus.rd_tail !== 16'h1830) $display("FAIL t1_rd_tail got=%h exp=1830", bus.rd_tail); else n_pass++;
    n_checks++; if (bus.cat_vld !== 1'b0) $display("FAIL t1_cat_vld got=%b exp=0", bus.cat_vld); else n_pass++;
    tick();
    n_checks++; if (bus.join_ack !== '0) $display("FAIL t1_ack_pulse got=%h exp=0", bus.join_ack); else n_pass++;
  endtask

  task automatic test_non_empty_join();
    join_req(4, 2, 5, 16'h2000, 16'h2040);
    tick();
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0010) $display("FAIL t2_ack got=%h exp=00000010", bus.join_ack); else n_pass++;
    n_checks++; if (bus.cat_vld !== 1'b1) $display("FAIL t2_cat_vld got=%b exp=1", bus.cat_vld); else n_pass++;
    n_checks++; if (bus.cat_prev !== 16'h1830) $display("FAIL t2_cat_prev got=%h exp=1830", bus.cat_prev); else n_pass++;
    n_checks++; if (bus.cat_next !== 16'h2000) $display("FAIL t2_cat_next got=%h exp=2000", bus.cat_next); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== {16'h1800, 16'h2040}) $display("FAIL t2_rd got=%h/%h exp=1800/2040", bus.rd_head, bus.rd_tail); else n_pass++;
    tick();
    n_checks++; if (bus.cat_vld !== 1'b0) $display("FAIL t2_cat_clear got=%b exp=0", bus.cat_vld); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_ordering();
    logic [NUM_SRAM-1:0] ack_val [4];
    int ack_cyc [4];
    logic [NUM_SRAM-1:0] exp_val [4];
    int n;
    exp_val[0] = 32'h0000_0002; exp_val[1] = 32'h0000_0010;
    exp_val[2] = 32'h0000_0200; exp_val[3] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin ack_val[i] = '0; ack_cyc[i] = -1; end
    n = 0;
    join_req(9, 3, 0, 16'h9000, 16'h9010);
    join_req(4, 3, 1, 16'h4000, 16'h4010);
    join_req(1, 3, 2, 16'h1000, 16'h1010);
    tick();
    join_req(0, 3, 3, 16'h0a00, 16'h0a10);
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (bus.join_ack !== '0 && n < 4) begin
        ack_val[n] = bus.join_ack;
        ack_cyc[n] = c;
        n++;
      end
    end
    n_checks++; if (n !== 4) $display("FAIL t3_ack_count got=%0d exp=4", n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ack_val[i] !== exp_val[i]) $display("FAIL t3_ack_order%0d got=%h exp=%h", i, ack_val[i], exp_val[i]); else n_pass++;
    end
    n_checks++; if (ack_cyc[0] !== 2) $display("FAIL t3_latency got=%0d exp=2", ack_cyc[0]); else n_pass++;
    n_checks++; if (ack_cyc[1] !== 3 || ack_cyc[2] !== 4) $display("FAIL t3_consecutive got=%0d,%0d exp=3,4", ack_cyc[1], ack_cyc[2]); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    bus.rd_port = 4'd2; bus.rd_prior = 3'd5;
    bus.cat_ready = 1'b0;
    join_req(5, 2, 5, 16'h3000, 16'h3040);
    tick();
    join_req(6, 2, 5, 16'h4000, 16'h4040);
    join_req(7, 2, 5, 16'h5000, 16'h5040);
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0020) $display("FAIL t4_ack5 got=%h exp=00000020", bus.join_ack); else n_pass++;
    n_checks++; if ({bus.cat_vld, bus.cat_prev, bus.cat_next} !== {1'b1, 16'h2040, 16'h3000}) $display("FAIL t4_cat_first got=%b %h %h exp=1 2040 3000", bus.cat_vld, bus.cat_prev, bus.cat_next); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (bus.join_ack !== '0) $display("FAIL t4_stall_ack%0d got=%h exp=0", c, bus.join_ack); else n_pass++;
      n_checks++; if ({bus.cat_vld, bus.cat_prev, bus.cat_next} !== {1'b1, 16'h2040, 16'h3000}) $display("FAIL t4_stall_cat%0d got=%b %h %h exp=1 2040 3000", c, bus.cat_vld, bus.cat_prev, bus.cat_next); else n_pass++;
    end
    bus.cat_ready = 1'b1;
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0040) $display("FAIL t4_ack6 got=%h exp=00000040", bus.join_ack); else n_pass++;
    n_checks++; if ({bus.cat_vld, bus.cat_prev, bus.cat_next} !== {1'b1, 16'h3040, 16'h4000}) $display("FAIL t4_cat6 got=%b %h %h exp=1 3040 4000", bus.cat_vld, bus.cat_prev, bus.cat_next); else n_pass++;
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0080) $display("FAIL t4_ack7 got=%h exp=00000080", bus.join_ack); else n_pass++;
    n_checks++; if ({bus.cat_vld, bus.cat_prev, bus.cat_next} !== {1'b1, 16'h4040, 16'h5000}) $display("FAIL t4_cat7 got=%b %h %h exp=1 4040 5000", bus.cat_vld, bus.cat_prev, bus.cat_next); else n_pass++;
    tick();
    n_checks++; if (bus.cat_vld !== 1'b0) $display("FAIL t4_cat_clear got=%b exp=0", bus.cat_vld); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== {16'h1800, 16'h5040}) $display("FAIL t4_rd got=%h/%h exp=1800/5040", bus.rd_head, bus.rd_tail); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_overlap();
    bus.rd_port = 4'd0; bus.rd_prior = 3'd0;
    join_req(10, 0, 0, 16'h0100, 16'h0110);
    tick();
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0400) $display("FAIL t5_ack10 got=%h exp=00000400", bus.join_ack); else n_pass++;
    n_checks++; if (bus.rd_head !== 16'h0100) $display("FAIL t5_first_head got=%h exp=0100", bus.rd_head); else n_pass++;
    repeat (2) tick();
    join_req(11, 0, 0, 16'h0200, 16'h0210);
    tick();
    bus.deq_vld = 1'b1; bus.deq_port = 4'd0; bus.deq_prior = 3'd0;
    bus.deq_last = 1'b1; bus.deq_next_head = 16'hdead;
    tick();
    n_checks++; if (bus.join_ack !== 32'h0000_0800) $display("FAIL t5_ack11 got=%h exp=00000800", bus.join_ack); else n_pass++;
    n_checks++; if (bus.cat_vld !== 1'b0) $display("FAIL t5_cat_vld got=%b exp=0", bus.cat_vld); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== {16'h0200, 16'h0210}) $display("FAIL t5_rd got=%h/%h exp=0200/0210", bus.rd_head, bus.rd_tail); else n_pass++;
    n_checks++; if (bus.q_empty[0] !== 1'b0) $display("FAIL t5_q_empty0 got=%b exp=0", bus.q_empty[0]); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL t5_err got=%b exp=0", bus.err); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_errors_and_reset();
    bus.rd_port = 4'd5; bus.rd_prior = 3'd5;
    bus.deq_vld = 1'b1; bus.deq_port = 4'd5; bus.deq_prior = 3'd5;
    bus.deq_last = 1'b0; bus.deq_next_head = 16'hbeef;
    tick();
    n_checks++; if (bus.err !== 1'b1) $display("FAIL t6_err got=%b exp=1", bus.err); else n_pass++;
    n_checks++; if (bus.q_empty[45] !== 1'b1) $display("FAIL t6_q_empty45 got=%b exp=1", bus.q_empty[45]); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== 32'h0) $display("FAIL t6_rd_unchanged got=%h/%h exp=0/0", bus.rd_head, bus.rd_tail); else n_pass++;
    // Put a request and a concatenation in flight, then reset for one cycle.
    bus.rd_port = 4'd2; bus.rd_prior = 3'd5;
    join_req(12, 2, 5, 16'h6000, 16'h6040);
    tick();
    join_req(13, 1, 1, 16'h7000, 16'h7040);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if ({bus.join_ack, bus.cat_vld, bus.err, bus.join_stall} !== 35'h0) $display("FAIL t6_rst_ctrl got=%h %b %b %b exp=0 0 0 0", bus.join_ack, bus.cat_vld, bus.err, bus.join_stall); else n_pass++;
    n_checks++; if ({bus.cat_prev, bus.cat_next} !== 32'h0) $display("FAIL t6_rst_cat got=%h/%h exp=0/0", bus.cat_prev, bus.cat_next); else n_pass++;
    n_checks++; if (bus.q_empty !== {NUM_Q{1'b1}}) $display("FAIL t6_rst_q_empty got=%h exp=all ones", bus.q_empty); else n_pass++;
    n_checks++; if ({bus.rd_head, bus.rd_tail} !== 32'h0) $display("FAIL t6_rst_rd got=%h/%h exp=0/0", bus.rd_head, bus.rd_tail); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if ({bus.join_ack, bus.cat_vld} !== 33'h0) $display("FAIL t6_post_rst%0d got=%h %b exp=0 0", c, bus.join_ack, bus.cat_vld); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.time_stamp = '0;
    bus.join_new = '0; bus.join_ts = '0; bus.join_dest = '0; bus.join_prior = '0;
    bus.join_head = '0; bus.join_tail = '0;
    bus.cat_ready = 1'b1;
    bus.deq_vld = 1'b0; bus.deq_port = '0; bus.deq_prior = '0;
    bus.deq_next_head = '0; bus.deq_last = 1'b0;
    bus.rd_port = '0; bus.rd_prior = '0;

    test_reset();
    test_empty_join();
    test_non_empty_join();
    test_ordering();
    test_backpressure();
    test_overlap();
    test_errors_and_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
